// File: rtl/mem_system.sv
// Data-side memory responder: shared word RAM serving a scalar port and a 128-bit
// vector port, plus memory-mapped LEDs, debounced switches and a cycle counter.
module mem_system #(
  parameter int          DEPTH_WORDS     = 4096,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] LED_ADDR        = 32'h0001_0000,
  parameter logic [31:0] SW_ADDR         = 32'h0001_0004,
  parameter logic [31:0] CYC_ADDR        = 32'h0001_0008
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  addr_a,
  input  logic [31:0]  wdata_a,
  input  logic         we_a,
  output logic [31:0]  rdata_a,
  input  logic [31:0]  addr_b,
  input  logic [127:0] wdata_b,
  input  logic         we_b,
  output logic [127:0] rdata_b,
  input  logic [2:0]   switches,
  output logic [7:0]   leds
);

  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int LINES = DEPTH_WORDS / 4;
  localparam int CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   cycCount;
  logic [2:0]    swSync1;
  logic [2:0]    swSync2;
  logic [2:0]    swDb;
  logic [CW-1:0] dbCnt [3];

  logic          aInRam;
  logic          bInRam;
  logic [AW-1:0] wordA;
  logic [AW-1:0] baseB;
  logic          isLed;
  logic          isSw;
  logic          isCyc;
  logic [31:0]   readA;
  logic [127:0]  readB;
  logic [5:0]    unusedBits;

  assign unusedBits = {addr_a[1:0], addr_b[3:0]};

  // Range checks use the full address so out-of-range accesses never alias into the RAM.
  assign aInRam = ({2'b00, addr_a[31:2]} < 32'(DEPTH_WORDS));
  assign bInRam = ({4'b0000, addr_b[31:4]} < 32'(LINES));
  assign wordA  = AW'(addr_a[31:2]);
  assign baseB  = AW'({addr_b[31:4], 2'b00});
  assign isLed  = (addr_a == LED_ADDR);
  assign isSw   = (addr_a == SW_ADDR);
  assign isCyc  = (addr_a == CYC_ADDR);

  // Port b is written after port a, so its lane wins a same-word collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (we_a && aInRam) begin
        mem[wordA] <= wdata_a;
      end
      if (we_b && bInRam) begin
        for (int k = 0; k < 4; k++) begin
          mem[baseB | AW'(k)] <= wdata_b[32*k +: 32];
        end
      end
    end
  end

  // The counter read reports the count as it stands right after the read's edge,
  // so a read following a clear sees 1 and a read at 0xFFFF_FFFF sees the wrap.
  always_comb begin
    readA = '0;
    if (aInRam) begin
      readA = mem[wordA];
    end else if (isLed) begin
      readA = {24'b0, leds};
    end else if (isSw) begin
      readA = {29'b0, swDb};
    end else if (isCyc) begin
      readA = cycCount + 32'd1;
    end
  end

  always_comb begin
    readB = '0;
    if (bInRam) begin
      for (int k = 0; k < 4; k++) begin
        readB[32*k +: 32] = mem[baseB | AW'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      rdata_a <= readA;
      rdata_b <= readB;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leds     <= '0;
      cycCount <= '0;
    end else begin
      if (we_a && isLed) begin
        leds <= wdata_a[7:0];
      end
      if (we_a && isCyc) begin
        cycCount <= '0;
      end else begin
        cycCount <= cycCount + 32'd1;
      end
    end
  end

  // Each switch bit must differ from its accepted value for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      swSync1 <= '0;
      swSync2 <= '0;
      swDb    <= '0;
      for (int i = 0; i < 3; i++) begin
        dbCnt[i] <= '0;
      end
    end else begin
      swSync1 <= switches;
      swSync2 <= swSync1;
      for (int i = 0; i < 3; i++) begin
        if (swSync2[i] == swDb[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == CNT_LAST) begin
          swDb[i]  <= swSync2[i];
          dbCnt[i] <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_system.sv
// Directed bench for mem_system: table of port accesses with hand-computed read data,
// plus sequences for reset, cycle counter and switch debounce timing.
module tb_mem_system;

  localparam int          DEPTH = 64;
  localparam int          DEB   = 4;
  localparam logic [31:0] LED_A = 32'h0001_0000;
  localparam logic [31:0] SW_A  = 32'h0001_0004;
  localparam logic [31:0] CYC_A = 32'h0001_0008;
  localparam logic [127:0] V1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] V2 = 128'h4444_4444_3333_3333_5555_5555_1111_1111;
  localparam logic [127:0] V3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  logic         clk;
  logic         reset;
  logic [31:0]  addr_a;
  logic [31:0]  wdata_a;
  logic         we_a;
  logic [31:0]  rdata_a;
  logic [31:0]  addr_b;
  logic [127:0] wdata_b;
  logic         we_b;
  logic [127:0] rdata_b;
  logic [2:0]   switches;
  logic [7:0]   leds;

  mem_system #(.DEPTH_WORDS(DEPTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset),
    .addr_a(addr_a), .wdata_a(wdata_a), .we_a(we_a), .rdata_a(rdata_a),
    .addr_b(addr_b), .wdata_b(wdata_b), .we_b(we_b), .rdata_b(rdata_b),
    .switches(switches), .leds(leds)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string        name;
    logic         weA;
    logic [31:0]  addrA;
    logic [31:0]  wdA;
    logic         weB;
    logic [31:0]  addrB;
    logic [127:0] wdB;
    logic         chkA;
    logic [31:0]  expA;
    logic         chkB;
    logic [127:0] expB;
  } vec_t;

  vec_t         vecs[$];
  logic [31:0]  exp_q[$];
  logic [127:0] expb_q[$];
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string n, input logic wa, input logic [31:0] aa,
                              input logic [31:0] da, input logic wb, input logic [31:0] ab,
                              input logic [127:0] db, input logic ca, input logic [31:0] ea,
                              input logic cb, input logic [127:0] eb);
    vec_t v;
    v.name = n; v.weA = wa; v.addrA = aa; v.wdA = da; v.weB = wb; v.addrB = ab;
    v.wdB = db; v.chkA = ca; v.expA = ea; v.chkB = cb; v.expB = eb;
    vecs.push_back(v);
  endfunction

  // driver tasks
  task automatic drive_a(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    we_a = we; addr_a = addr; wdata_a = wd;
    we_b = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    we_a = v.weA; addr_a = v.addrA; wdata_a = v.wdA;
    we_b = v.weB; addr_b = v.addrB; wdata_b = v.wdB;
    if (v.chkA) exp_q.push_back(v.expA);
    if (v.chkB) expb_q.push_back(v.expB);
    tick();
    if (v.chkA) check({v.name, "_a"}, 128'(rdata_a), 128'(exp_q.pop_front()));
    if (v.chkB) check({v.name, "_b"}, rdata_b, expb_q.pop_front());
  endtask

  initial begin
    int  hit;
    logic sawOne;

    // read-first, latency, lane mapping, collision, out-of-range, LED
    add("pre10",  1, 32'h10, 32'h1234_5678, 0, 0, '0, 0, 0, 0, '0);
    add("rf10",   1, 32'h10, 32'hDEAD_BEEF, 0, 0, '0, 1, 32'h1234_5678, 0, '0);
    add("rd10",   0, 32'h10, 0, 0, 0, '0, 1, 32'hDEAD_BEEF, 0, '0);
    add("vwr",    0, 32'h10, 0, 1, 32'h20, V1, 1, 32'hDEAD_BEEF, 0, '0);
    add("v20",    0, 32'h20, 0, 0, 32'h20, '0, 1, 32'h1111_1111, 1, V1);
    add("v24",    0, 32'h24, 0, 0, 32'h2F, '0, 1, 32'h2222_2222, 1, V1);
    add("v28",    0, 32'h28, 0, 0, 0, '0, 1, 32'h3333_3333, 0, '0);
    add("v2c",    0, 32'h2C, 0, 0, 0, '0, 1, 32'h4444_4444, 0, '0);
    add("coll",   1, 32'h24, 32'hAAAA_AAAA, 1, 32'h20, V2, 1, 32'h2222_2222, 1, V1);
    add("coll24", 0, 32'h24, 0, 0, 32'h20, '0, 1, 32'h5555_5555, 1, V2);
    add("aoth",   1, 32'h30, 32'hCAFE_F00D, 1, 32'h20, V1, 0, 0, 0, '0);
    add("rd30",   0, 32'h30, 0, 0, 32'h20, '0, 1, 32'hCAFE_F00D, 1, V1);
    add("b0",     0, 32'h10, 0, 1, 32'h00, V3, 0, 0, 0, '0);
    add("boorw",  0, 32'h00, 0, 1, 32'h400, ~V3, 1, V3[31:0], 0, '0);
    add("boorr",  0, 32'h04, 0, 0, 32'h400, '0, 1, V3[63:32], 1, '0);
    add("rdb0",   0, 32'h0C, 0, 0, 32'h00, '0, 1, V3[127:96], 1, V3);
    add("aoor",   1, 32'h100, 32'hFFFF_FFFF, 0, 0, '0, 1, 32'h0, 0, '0);
    add("rd0",    0, 32'h00, 0, 0, 32'h00, '0, 1, V3[31:0], 1, V3);
    add("far",    0, 32'h0002_0000, 0, 0, 0, '0, 1, 32'h0, 0, '0);
    add("ledw",   1, LED_A, 32'h0000_01A5, 0, 0, '0, 1, 32'h0, 0, '0);
    add("ledr",   0, LED_A, 0, 0, 0, '0, 1, 32'h0000_00A5, 0, '0);

    reset = 1'b1; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    we_b = 1'b0; addr_b = '0; wdata_b = '0; switches = 3'b000;
    tick(); tick();
    @(negedge clk);
    reset = 1'b0;
    check("rst_rdata_a", 128'(rdata_a), 128'h0);
    check("rst_rdata_b", rdata_b, 128'h0);
    check("rst_leds", 128'(leds), 128'h0);

    foreach (vecs[i]) apply(vecs[i]);
    check("leds_out", 128'(leds), 128'hA5);

    // reset suppresses a concurrent RAM write and clears rdata/leds
    @(negedge clk);
    reset = 1'b1; we_a = 1'b1; addr_a = 32'h10; wdata_a = 32'h0000_0099;
    tick();
    check("rst_mid_rdata", 128'(rdata_a), 128'h0);
    check("rst_mid_leds", 128'(leds), 128'h0);
    @(negedge clk);
    reset = 1'b0; we_a = 1'b0;
    tick();
    check("rst_write_blocked", 128'(rdata_a), 128'hDEAD_BEEF);

    // cycle counter clear, increment, wrap
    drive_a(1'b1, CYC_A, 32'h0);
    tick();
    drive_a(1'b0, CYC_A, 32'h0);
    tick();
    check("cyc_after_clr", 128'(rdata_a), 128'd1);
    tick();
    check("cyc_incr", 128'(rdata_a), 128'd2);
    @(negedge clk);
    force dut.cycCount = 32'hFFFF_FFFF;
    tick();
    release dut.cycCount;
    check("cyc_wrap", 128'(rdata_a), 128'h0);

    // switch glitch shorter than the debounce window is rejected
    drive_a(1'b0, SW_A, 32'h0);
    switches = 3'b001;
    sawOne = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rdata_a != 32'h0) sawOne = 1'b1;
    end
    @(negedge clk);
    switches = 3'b000;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rdata_a != 32'h0) sawOne = 1'b1;
    end
    check("sw_glitch", 128'(sawOne), 128'h0);

    // held switch is accepted after 2 sync + DEB cycles; read shows it one edge later
    @(negedge clk);
    switches = 3'b001;
    hit = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (hit < 0 && rdata_a == 32'h1) hit = k;
    end
    check("sw_latency", 128'(hit), 128'(2 + DEB + 1));
    check("sw_value", 128'(rdata_a), 128'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
